// File: rtl/decoder_nto2n_stream_if.sv
// decoder_nto2n_stream_if: valid/ready bundle between code producer, decoder and one-hot consumer
interface decoder_nto2n_stream_if #(
  parameter int IN_W = 4
);
  localparam int OUT_W = 2 ** IN_W;
  logic en;
  logic mode;
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] in;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] out;
  logic scan_wrap;
  modport master (
    output en, mode, in_valid, in, out_ready,
    input in_ready, out_valid, out, scan_wrap
  );
  modport slave (
    input en, mode, in_valid, in, out_ready,
    output in_ready, out_valid, out, scan_wrap
  );
endinterface

// File: rtl/decoder_nto2n_stream.sv
// decoder_nto2n_stream: registered IN_W-to-2^IN_W one-hot decoder on a valid/ready stream; auto-scan under DECODER_SCAN_EN
module decoder_nto2n_stream #(
  parameter int IN_W = 4,
  parameter int SCAN_STEP = 1
) (
  input logic clk,
  input logic rst,
  decoder_nto2n_stream_if.slave s
);
  localparam int OUT_W = 2 ** IN_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DEC = 2'd1;
  logic [1:0] state;
  logic [OUT_W-1:0] word;
  logic slot_free;
  logic scan_mode;
  logic dec_load;
  assign slot_free = state == IDLE || s.out_ready;
  assign s.in_ready = !scan_mode && slot_free;
  assign dec_load = s.in_valid && s.in_ready;
  assign s.out_valid = state != IDLE;
  assign s.out = word;
`ifdef DECODER_SCAN_EN
  localparam logic [1:0] SCAN = 2'd2;
  logic [IN_W-1:0] idx;
  logic [IN_W-1:0] idx_next;
  logic [IN_W:0] idx_sum;
  logic prev_scan;
  logic wrap;
  logic scan_load;
  assign scan_mode = s.mode;
  assign scan_load = s.mode && s.en && slot_free;
  assign idx_sum = {1'b0, idx} + (IN_W + 1)'(SCAN_STEP);
  // prev_scan survives a pause so the sweep resumes one step further on
  assign idx_next = prev_scan ? idx_sum[IN_W-1:0] : idx;
  assign s.scan_wrap = wrap;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      word <= '0;
      idx <= '0;
      prev_scan <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (dec_load) begin
        state <= DEC;
        word <= s.en ? OUT_W'(1) << s.in : '0;
        idx <= '0;
        prev_scan <= 1'b0;
      end else if (scan_load) begin
        state <= SCAN;
        word <= OUT_W'(1) << idx_next;
        idx <= idx_next;
        prev_scan <= 1'b1;
        wrap <= prev_scan && idx_sum[IN_W];
      end else if (slot_free) begin
        state <= IDLE;
        word <= '0;
      end
    end
`else
  assign scan_mode = 1'b0;
  assign s.scan_wrap = 1'b0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      word <= '0;
    end else if (dec_load) begin
      state <= DEC;
      word <= s.en ? OUT_W'(1) << s.in : '0;
    end else if (slot_free) begin
      state <= IDLE;
      word <= '0;
    end
`endif
endmodule

// File: tb/tb_decoder_nto2n_stream.sv
// tb_decoder_nto2n_stream: scoreboard bench for decoder_nto2n_stream; scan scenarios under DECODER_SCAN_EN
module tb_decoder_nto2n_stream;
  localparam int IN_W = 4;
  localparam int OUT_W = 16;
  typedef struct packed {
    logic [OUT_W-1:0] word;
    logic wrap;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  decoder_nto2n_stream_if #(.IN_W(IN_W)) dif ();
  decoder_nto2n_stream #(.IN_W(IN_W), .SCAN_STEP(1)) dut (.clk(clk), .rst(rst), .s(dif));
`ifdef DECODER_SCAN_EN
  decoder_nto2n_stream_if #(.IN_W(IN_W)) dif3 ();
  decoder_nto2n_stream #(.IN_W(IN_W), .SCAN_STEP(3)) dut3 (.clk(clk), .rst(rst), .s(dif3));
`endif
  always @(negedge clk) begin
    exp_t e;
    if (!rst && dif.out_valid && dif.out_ready) begin
      total++;
      if (sb.size() == 0)
        $display("FAIL sb_unexpected got %h/%b expected no word", dif.out, dif.scan_wrap);
      else begin
        e = sb.pop_front();
        if ({dif.out, dif.scan_wrap} !== e)
          $display("FAIL sb_word got %h/%b expected %h/%b", dif.out, dif.scan_wrap, e.word, e.wrap);
        else
          pass_cnt++;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL sim_timeout got running expected finished");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [IN_W-1:0] c, input logic e_b);
    exp_t e;
    int n;
    n = 0;
    dif.in_valid = 1'b1;
    dif.in = c;
    dif.en = e_b;
    @(negedge clk);
    while (!dif.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dif.in_ready) begin
      total++;
      $display("FAIL send_timeout got in_ready=0 expected 1");
    end else begin
      e.word = '0;
      if (e_b) e.word[c] = 1'b1;
      e.wrap = 1'b0;
      sb.push_back(e);
    end
    step();
    dif.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    step();
    total++;
    if (sb.size() != 0 || dif.out_valid !== 1'b0)
      $display("FAIL drain got %0d pending/valid=%b expected 0/0", sb.size(), dif.out_valid);
    else
      pass_cnt++;
  endtask
  task automatic test_reset();
    sb.delete();
    rst = 1'b1;
    dif.en = 1'b1;
    dif.mode = 1'b0;
    dif.in_valid = 1'b1;
    dif.in = 4'hA;
    dif.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (dif.out_valid !== 1'b0 || dif.out !== 16'h0000)
        $display("FAIL reset_state got %h/%b expected 0000/0", dif.out, dif.out_valid);
      else
        pass_cnt++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    dif.in_valid = 1'b0;
    send(4'hA, 1'b1);
    total++;
    if (dif.out !== 16'h0400 || dif.out_valid !== 1'b1)
      $display("FAIL decode_latency got %h/%b expected 0400/1", dif.out, dif.out_valid);
    else
      pass_cnt++;
    drain();
  endtask
  task automatic test_backpressure();
    dif.out_ready = 1'b0;
    send(4'h3, 1'b1);
    dif.in_valid = 1'b1;
    dif.in = 4'h7;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (dif.out !== 16'h0008 || dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0)
        $display("FAIL bp_hold got %h/%b/%b expected 0008/1/0", dif.out, dif.out_valid, dif.in_ready);
      else
        pass_cnt++;
    end
    @(posedge clk);
    #1;
    dif.out_ready = 1'b1;
    send(4'h7, 1'b1);
    send(4'hF, 1'b1);
    drain();
  endtask
  task automatic test_en0();
    send(4'h5, 1'b0);
    total++;
    if (dif.out !== 16'h0000 || dif.out_valid !== 1'b1)
      $display("FAIL en0_word got %h/%b expected 0000/1", dif.out, dif.out_valid);
    else
      pass_cnt++;
    drain();
    dif.en = 1'b1;
  endtask
  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 16; i++)
      send(IN_W'((i * 7) % 16), $urandom_range(0, 3) != 0);
    total++;
    if (cyc - c0 !== 16)
      $display("FAIL b2b_cycles got %0d expected 16", cyc - c0);
    else
      pass_cnt++;
    drain();
    dif.en = 1'b1;
  endtask
`ifdef DECODER_SCAN_EN
  task automatic test_sweep();
    exp_t e;
    for (int i = 0; i < 17; i++) begin
      e.word = '0;
      e.word[i % 16] = 1'b1;
      e.wrap = i == 16;
      sb.push_back(e);
    end
    dif.out_ready = 1'b1;
    dif.en = 1'b1;
    dif.mode = 1'b1;
    repeat (17) step();
    dif.en = 1'b0;
    drain();
    dif.mode = 1'b0;
    dif.en = 1'b1;
  endtask
  task automatic test_pause_step_reset();
    logic [OUT_W-1:0] exp_w[7];
    logic exp_wrap[7];
    exp_w = '{16'h0001, 16'h0008, 16'h0040, 16'h0200, 16'h1000, 16'h8000, 16'h0004};
    exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dif3.out_ready = 1'b1;
    dif3.in_valid = 1'b0;
    dif3.in = '0;
    dif3.en = 1'b1;
    dif3.mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        dif3.en = 1'b0;
        repeat (4) begin
          step();
          total++;
          if (dif3.out_valid !== 1'b0)
            $display("FAIL pause_valid got %b expected 0", dif3.out_valid);
          else
            pass_cnt++;
        end
        dif3.en = 1'b1;
      end
      step();
      total++;
      if (dif3.out !== exp_w[i] || dif3.out_valid !== 1'b1 || dif3.scan_wrap !== exp_wrap[i])
        $display("FAIL step3_word%0d got %h/%b/%b expected %h/1/%b", i, dif3.out, dif3.out_valid, dif3.scan_wrap, exp_w[i], exp_wrap[i]);
      else
        pass_cnt++;
    end
    rst = 1'b1;
    step();
    total++;
    if (dif3.out !== 16'h0000 || dif3.out_valid !== 1'b0 || dif3.scan_wrap !== 1'b0)
      $display("FAIL scan_reset got %h/%b/%b expected 0000/0/0", dif3.out, dif3.out_valid, dif3.scan_wrap);
    else
      pass_cnt++;
    rst = 1'b0;
    step();
    total++;
    if (dif3.out !== 16'h0001 || dif3.out_valid !== 1'b1)
      $display("FAIL scan_after_reset got %h/%b expected 0001/1", dif3.out, dif3.out_valid);
    else
      pass_cnt++;
    dif3.en = 1'b0;
    dif3.mode = 1'b0;
  endtask
`else
  task automatic test_macro_off();
    dif.mode = 1'b1;
    step();
    total++;
    if (dif.in_ready !== 1'b1)
      $display("FAIL macro_off_ready got %b expected 1", dif.in_ready);
    else
      pass_cnt++;
    send(4'h2, 1'b1);
    total++;
    if (dif.out !== 16'h0004 || dif.scan_wrap !== 1'b0)
      $display("FAIL macro_off_word got %h/%b expected 0004/0", dif.out, dif.scan_wrap);
    else
      pass_cnt++;
    drain();
    dif.mode = 1'b0;
  endtask
`endif
  initial begin
`ifdef DECODER_SCAN_EN
    dif3.out_ready = 1'b1;
    dif3.in_valid = 1'b0;
    dif3.in = '0;
    dif3.en = 1'b0;
    dif3.mode = 1'b0;
`endif
    test_reset();
    test_backpressure();
    test_en0();
    test_back_to_back();
`ifdef DECODER_SCAN_EN
    test_sweep();
    test_pause_step_reset();
`else
    test_macro_off();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
